pwr_mgr_seq: RTL and testbench

//  Parametrised power sequencer between board pins and the SoC core. Holds the SoC in

---
 rtl/pwr_mgr_seq_pkg.sv | 18 +
 rtl/pwr_mgr_seq_timer.sv | 27 ++
 rtl/pwr_mgr_seq.sv | 159 +++++++++++++++
 tb/tb_pwr_mgr_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_mgr_seq_pkg.sv
// Shared definitions for the power sequencer: state encodings (also used by the
// software status register map) and parameter helpers.
package pwr_mgr_seq_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_DRAIN = 2'b11
  } pwr_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pwr_mgr_seq_timer.sv
// Loadable down-counter that parks at zero; load wins over decrement.
module pwr_mgr_seq_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pwr_mgr_seq.sv
// Power sequencer: holds the SoC in reset until a masked wake, stretches reset,
// runs, drains on poweroff and returns to OFF behind a wake cooldown.
//   state    | meaning
//   ST_OFF   | SoC in reset, pads idle, cooldown running, waiting for wake
//   ST_HOLD  | wake accepted, soc_resetn stretched low for RESET_HOLD_CYCLES
//   ST_RUN   | SoC live, pads follow SoC
//   ST_DRAIN | poweroff requested, waiting for soc_idle or drain timeout
module pwr_mgr_seq
  import pwr_mgr_seq_pkg::*;
#(
  parameter int                   NUM_WAKE          = 2,
  parameter logic [NUM_WAKE-1:0]  WAKE_MASK         = 2'b01,
  parameter int                   NUM_GATED         = 2,
  parameter logic [NUM_GATED-1:0] GATE_IDLE         = 2'b11,
  parameter int                   RESET_HOLD_CYCLES = 4,
  parameter int                   DRAIN_CYCLES      = 16,
  parameter int                   COOLDOWN_CYCLES   = 8,
  parameter int                   BOOT_CNT_W        = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_WAKE-1:0]   i_wake_req,
  input  logic                  i_poweroff_rq,
  input  logic                  i_soc_idle,
  input  logic [NUM_GATED-1:0]  i_soc_out,
  output logic [NUM_GATED-1:0]  o_pad_out,
  output logic                  o_soc_resetn,
  output logic [1:0]            o_state,
  output logic [NUM_WAKE-1:0]   o_wake_cause,
  output logic [BOOT_CNT_W-1:0] o_boot_count
);

  localparam int TW = $clog2(max3(RESET_HOLD_CYCLES, DRAIN_CYCLES, COOLDOWN_CYCLES) + 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(RESET_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] DRAIN_LOAD = TW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  localparam logic [TW-1:0] CD_LOAD    = TW'(COOLDOWN_CYCLES);

  pwr_state_e            r_state;
  pwr_state_e            w_state_nxt;
  logic                  r_soc_resetn;
  logic                  w_resetn_nxt;
  logic [NUM_WAKE-1:0]   r_wake_cause;
  logic [BOOT_CNT_W-1:0] r_boot_count;

  logic [NUM_WAKE-1:0]   w_wake_masked;
  logic                  w_tmr_load;
  logic [TW-1:0]         w_tmr_val;
  logic                  w_tmr_dec;
  logic                  w_tmr_zero;
  logic                  w_cd_load;
  logic                  w_cd_dec;
  logic                  w_cd_zero;
  logic                  w_cause_load;
  logic                  w_boot_inc;

  assign w_wake_masked = i_wake_req & WAKE_MASK;
  assign w_tmr_dec     = (r_state == ST_HOLD) || (r_state == ST_DRAIN);
  assign w_cd_dec      = (r_state == ST_OFF);

  // One timer serves both HOLD and DRAIN since they never overlap.
  pwr_mgr_seq_timer #(.W(TW)) u_phase_tmr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .i_dec   (w_tmr_dec),
    .o_zero  (w_tmr_zero)
  );

  pwr_mgr_seq_timer #(.W(TW)) u_cooldown_tmr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_cd_load),
    .i_value (CD_LOAD),
    .i_dec   (w_cd_dec),
    .o_zero  (w_cd_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_OFF;
      r_soc_resetn <= 1'b0;
      r_wake_cause <= '0;
      r_boot_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_soc_resetn <= w_resetn_nxt;
      if (w_cause_load) begin
        r_wake_cause <= w_wake_masked;
      end
      if (w_boot_inc && (r_boot_count != {BOOT_CNT_W{1'b1}})) begin
        r_boot_count <= r_boot_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_resetn_nxt = r_soc_resetn;
    w_tmr_load   = 1'b0;
    w_tmr_val    = HOLD_LOAD;
    w_cd_load    = 1'b0;
    w_cause_load = 1'b0;
    w_boot_inc   = 1'b0;
    case (r_state)
      ST_OFF: begin
        w_resetn_nxt = 1'b0;
        if (w_cd_zero && (|w_wake_masked)) begin
          w_state_nxt  = ST_HOLD;
          w_tmr_load   = 1'b1;
          w_tmr_val    = HOLD_LOAD;
          w_cause_load = 1'b1;
        end
      end
      ST_HOLD: begin
        w_resetn_nxt = 1'b0;
        if (w_tmr_zero) begin
          w_state_nxt  = ST_RUN;
          w_resetn_nxt = 1'b1;
          w_boot_inc   = 1'b1;
        end
      end
      ST_RUN: begin
        w_resetn_nxt = 1'b1;
        if (i_poweroff_rq) begin
          if (DRAIN_CYCLES == 0) begin
            w_state_nxt  = ST_OFF;
            w_resetn_nxt = 1'b0;
            w_cd_load    = 1'b1;
          end else begin
            w_state_nxt = ST_DRAIN;
            w_tmr_load  = 1'b1;
            w_tmr_val   = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        w_resetn_nxt = 1'b1;
        if (i_soc_idle || w_tmr_zero) begin
          w_state_nxt  = ST_OFF;
          w_resetn_nxt = 1'b0;
          w_cd_load    = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = ST_OFF;
        w_resetn_nxt = 1'b0;
      end
    endcase
  end

  // Pads are the only combinational outputs: SoC drives them only while live.
  assign o_pad_out    = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) ? i_soc_out : GATE_IDLE;
  assign o_soc_resetn = r_soc_resetn;
  assign o_state      = r_state;
  assign o_wake_cause = r_wake_cause;
  assign o_boot_count = r_boot_count;

endmodule

// File: tb/tb_pwr_mgr_seq.sv
// Directed bench for pwr_mgr_seq: default instance plus a 2-bit boot counter instance.
module tb_pwr_mgr_seq;
  import pwr_mgr_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] wake_req;
  logic       poweroff_rq;
  logic       soc_idle;
  logic [1:0] soc_out;

  logic [1:0] pad_out, state, wake_cause;
  logic       soc_resetn;
  logic [7:0] boot_count;

  logic [1:0] pad_out2, state2, wake_cause2;
  logic       soc_resetn2;
  logic [1:0] boot_count2;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwr_mgr_seq u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_wake_req    (wake_req),
    .i_poweroff_rq (poweroff_rq),
    .i_soc_idle    (soc_idle),
    .i_soc_out     (soc_out),
    .o_pad_out     (pad_out),
    .o_soc_resetn  (soc_resetn),
    .o_state       (state),
    .o_wake_cause  (wake_cause),
    .o_boot_count  (boot_count)
  );

  pwr_mgr_seq #(.BOOT_CNT_W(2)) u_dut2 (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_wake_req    (wake_req),
    .i_poweroff_rq (poweroff_rq),
    .i_soc_idle    (soc_idle),
    .i_soc_out     (soc_out),
    .o_pad_out     (pad_out2),
    .o_soc_resetn  (soc_resetn2),
    .o_state       (state2),
    .o_wake_cause  (wake_cause2),
    .o_boot_count  (boot_count2)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    wake_req    = 2'b00;
    poweroff_rq = 1'b0;
    soc_idle    = 1'b0;
    soc_out     = 2'b00;
    tick(2);

    // reset values, then idle with no wake
    chk("rst_state",  32'(state),      32'(ST_OFF));
    chk("rst_resetn", 32'(soc_resetn), 32'd0);
    chk("rst_pad",    32'(pad_out),    32'h3);
    chk("rst_cause",  32'(wake_cause), 32'd0);
    chk("rst_boot",   32'(boot_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_state", 32'(state), 32'(ST_OFF));
    end
    chk("idle_resetn", 32'(soc_resetn), 32'd0);
    chk("idle_pad",    32'(pad_out),    32'h3);

    // masked source only: never wakes
    wake_req = 2'b10;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("mask_state", 32'(state), 32'(ST_OFF));
    end
    chk("mask_cause", 32'(wake_cause), 32'd0);
    chk("mask_boot",  32'(boot_count), 32'd0);
    wake_req = 2'b00;
    tick();

    // wake latency: HOLD one edge later, resetn high 4 edges after that
    wake_req = 2'b01;
    tick();
    chk("wk_hold",   32'(state),      32'(ST_HOLD));
    chk("wk_rstn0",  32'(soc_resetn), 32'd0);
    wake_req = 2'b00;
    tick(3);
    chk("wk_hold3",  32'(state),      32'(ST_HOLD));
    chk("wk_rstn3",  32'(soc_resetn), 32'd0);
    chk("wk_padg",   32'(pad_out),    32'h3);
    tick();
    chk("wk_run",    32'(state),      32'(ST_RUN));
    chk("wk_rstn1",  32'(soc_resetn), 32'd1);
    chk("wk_cause",  32'(wake_cause), 32'h1);
    chk("wk_boot",   32'(boot_count), 32'd1);
    soc_out = 2'b01;
    #1;
    chk("wk_pad01",  32'(pad_out),    32'h1);
    soc_out = 2'b10;
    #1;
    chk("wk_pad10",  32'(pad_out),    32'h2);

    // drain exit on soc_idle in 3rd drain cycle; deasserting poweroff does not cancel
    poweroff_rq = 1'b1;
    tick();
    chk("dr_state1", 32'(state),      32'(ST_DRAIN));
    chk("dr_rstn1",  32'(soc_resetn), 32'd1);
    chk("dr_padlv",  32'(pad_out),    32'h2);
    poweroff_rq = 1'b0;
    tick();
    chk("dr_state2", 32'(state),      32'(ST_DRAIN));
    tick();
    chk("dr_state3", 32'(state),      32'(ST_DRAIN));
    soc_idle = 1'b1;
    tick();
    chk("dr_off",    32'(state),      32'(ST_OFF));
    chk("dr_rstn0",  32'(soc_resetn), 32'd0);
    chk("dr_padidl", 32'(pad_out),    32'h3);
    soc_idle = 1'b0;
    tick(10);

    // second wake with both sources: cause records only the enabled one
    wake_req = 2'b11;
    tick();
    chk("w2_hold",   32'(state),      32'(ST_HOLD));
    tick(4);
    chk("w2_run",    32'(state),      32'(ST_RUN));
    chk("w2_cause",  32'(wake_cause), 32'h1);
    chk("w2_boot",   32'(boot_count), 32'd2);

    // drain timeout with soc_idle low: exactly 16 drain cycles, wake held throughout
    poweroff_rq = 1'b1;
    tick();
    chk("to_drain1", 32'(state), 32'(ST_DRAIN));
    tick(15);
    chk("to_drain16", 32'(state), 32'(ST_DRAIN));
    chk("to_rstn16",  32'(soc_resetn), 32'd1);
    tick();
    chk("to_off",    32'(state),      32'(ST_OFF));
    chk("to_rstn0",  32'(soc_resetn), 32'd0);
    poweroff_rq = 1'b0;

    // cooldown: held wake ignored for 8 cycles, HOLD on the 9th
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("cd_off", 32'(state), 32'(ST_OFF));
    end
    tick();
    chk("cd_hold",   32'(state),      32'(ST_HOLD));
    tick(4);
    chk("cd_run",    32'(state),      32'(ST_RUN));
    chk("cd_boot",   32'(boot_count), 32'd3);
    wake_req = 2'b00;

    // reset in DRAIN aborts to OFF with no drain and clears cooldown
    poweroff_rq = 1'b1;
    tick();
    chk("ra_drain",  32'(state), 32'(ST_DRAIN));
    poweroff_rq = 1'b0;
    reset = 1'b1;
    tick();
    chk("ra_off",    32'(state),      32'(ST_OFF));
    chk("ra_rstn",   32'(soc_resetn), 32'd0);
    chk("ra_boot",   32'(boot_count), 32'd0);
    chk("ra_cause",  32'(wake_cause), 32'd0);
    chk("ra_pad",    32'(pad_out),    32'h3);
    reset = 1'b0;
    wake_req = 2'b01;
    tick();
    chk("ra_nocd",   32'(state),      32'(ST_HOLD));
    tick(2);
    reset = 1'b1;
    tick();
    chk("rh_off",    32'(state),      32'(ST_OFF));
    chk("rh_rstn",   32'(soc_resetn), 32'd0);
    chk("rh_boot",   32'(boot_count), 32'd0);
    reset = 1'b0;
    wake_req = 2'b00;
    tick();

    // five power cycles: 8-bit counter reaches 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      wake_req = 2'b01;
      tick();
      chk("pc_hold", 32'(state), 32'(ST_HOLD));
      tick(4);
      chk("pc_run",  32'(state), 32'(ST_RUN));
      chk("pc_boot8", 32'(boot_count),  32'(i + 1));
      chk("pc_boot2", 32'(boot_count2), 32'((i + 1 > 3) ? 3 : i + 1));
      wake_req    = 2'b00;
      poweroff_rq = 1'b1;
      soc_idle    = 1'b1;
      tick();
      chk("pc_drain", 32'(state), 32'(ST_DRAIN));
      tick();
      chk("pc_off",  32'(state), 32'(ST_OFF));
      poweroff_rq = 1'b0;
      soc_idle    = 1'b0;
      tick(8);
    end
    chk("pc_final8", 32'(boot_count),  32'd5);
    chk("pc_final2", 32'(boot_count2), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
